// File: rtl/adma_pkg.sv
// -----------------------------------------------------------------------------
// adma_pkg
// Shared types and helpers for the ADMA channel arbiters.
//   adma_chn_id_t  : channel index at the default channel count
//   adma_arb_st_e  : arbiter FSM states (IDLE / GRANT)
//   adma_quantum() : grants allowed per turn; a rate of 0 still earns one grant
// -----------------------------------------------------------------------------
package adma_pkg;

    localparam int ADMA_CHN_NUM   = 4;
    localparam int ADMA_CHN_ARB_W = 3;
    localparam int ADMA_CHN_ID_W  = $clog2(ADMA_CHN_NUM);

    // Wide enough for any realistic arbitration weight; callers cast in/out.
    localparam int ADMA_RATE_W    = 16;

    typedef logic [ADMA_CHN_ID_W-1:0] adma_chn_id_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } adma_arb_st_e;

    function automatic logic [ADMA_RATE_W-1:0] adma_quantum(input logic [ADMA_RATE_W-1:0] rate);
        return (rate == '0) ? ADMA_RATE_W'(1) : rate;
    endfunction

endpackage

// File: rtl/adma_rr_pick.sv
// -----------------------------------------------------------------------------
// adma_rr_pick
// Combinational round-robin picker: finds the first set bit of i_elig scanning
// upward from i_start and wrapping modulo REQ_NUM.
//   i_elig  : request/eligibility vector, bit i = requester i
//   i_start : index scanned first
//   o_found : at least one bit of i_elig is set
//   o_idx   : index of the selected requester (0 when nothing is found)
// -----------------------------------------------------------------------------
module adma_rr_pick #(
    parameter  int REQ_NUM = 4,
    localparam int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    logic [2*REQ_NUM-1:0] w_dbl;
    logic [2*REQ_NUM-1:0] w_rot;
    logic [IDX_W:0]       w_sum;

    // Rotating a doubled copy right by i_start puts requester i_start at bit 0,
    // so a plain lowest-set-bit search gives the wrapped scan order.
    assign w_dbl = {i_elig, i_elig};
    assign w_rot = w_dbl >> i_start;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        // Scan from the far end so the nearest set bit is the last one written.
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_start} + (IDX_W+1)'(k);
                if (w_sum >= (IDX_W+1)'(REQ_NUM)) begin
                    w_sum = w_sum - (IDX_W+1)'(REQ_NUM);
                end
                o_idx = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/adma_chn_arbiter.sv
// -----------------------------------------------------------------------------
// adma_chn_arbiter
// Weighted round-robin scheduler sharing the DMA's single burst-issue engine
// between DMA_CHN_NUM channels. Each selected channel gets up to its quantum
// (max(chn_arb_rate,1)) consecutive grants before the grant rotates.
//   aclk, areset   : clock, synchronous active-high reset
//   dma_en         : global enable; only blocks new selections
//   chn_ctrl_en[i] : per-channel enable
//   chn_arb_rate[i]: per-channel quantum (0 behaves as 1)
//   chn_req_i[i]   : channel i has a burst pending (in its accept cycle: another
//                    burst remains after this one)
//   grant_vld_o / grant_rdy_i : grant handshake towards the issue engine
//   grant_chn_o    : granted channel index
//   grant_oh_o     : one-hot grant, zero while grant_vld_o is low
//   grant_last_o   : grant is the last of the channel's current quantum
//   arb_busy_o     : FSM not idle
// -----------------------------------------------------------------------------
module adma_chn_arbiter
    import adma_pkg::*;
#(
    parameter  int DMA_CHN_NUM   = ADMA_CHN_NUM,
    parameter  int DMA_CHN_ARB_W = ADMA_CHN_ARB_W,
    localparam int DMA_CHN_ID_W  = $clog2(DMA_CHN_NUM)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     dma_en,
    input  logic                     chn_ctrl_en  [0:DMA_CHN_NUM-1],
    input  logic [DMA_CHN_ARB_W-1:0] chn_arb_rate [0:DMA_CHN_NUM-1],
    input  logic                     chn_req_i    [0:DMA_CHN_NUM-1],
    output logic                     grant_vld_o,
    input  logic                     grant_rdy_i,
    output logic [DMA_CHN_ID_W-1:0]  grant_chn_o,
    output logic [DMA_CHN_NUM-1:0]   grant_oh_o,
    output logic                     grant_last_o,
    output logic                     arb_busy_o
);

    adma_arb_st_e              r_state;
    logic [DMA_CHN_ID_W-1:0]   r_cur;
    logic [DMA_CHN_ARB_W-1:0]  r_credit;
    logic [DMA_CHN_ID_W-1:0]   r_rr_ptr;
    logic                      r_last;

    adma_arb_st_e              w_state_nxt;
    logic [DMA_CHN_ID_W-1:0]   w_cur_nxt;
    logic [DMA_CHN_ARB_W-1:0]  w_credit_nxt;
    logic [DMA_CHN_ID_W-1:0]   w_rr_ptr_nxt;
    logic                      w_last_nxt;

    logic [DMA_CHN_NUM-1:0]    w_elig;
    logic [DMA_CHN_ARB_W-1:0]  w_q [0:DMA_CHN_NUM-1];
    logic [DMA_CHN_ID_W-1:0]   w_cur_inc;
    logic                      w_accept;

    logic                      w_new_found;
    logic [DMA_CHN_ID_W-1:0]   w_new_idx;
    logic                      w_rot_found;
    logic [DMA_CHN_ID_W-1:0]   w_rot_idx;

    always_comb begin
        for (int i = 0; i < DMA_CHN_NUM; i++) begin
            w_elig[i] = dma_en & chn_ctrl_en[i] & chn_req_i[i];
            w_q[i]    = DMA_CHN_ARB_W'(adma_quantum(ADMA_RATE_W'(chn_arb_rate[i])));
        end
    end

    assign w_cur_inc = (r_cur == DMA_CHN_ID_W'(DMA_CHN_NUM - 1)) ? '0 : r_cur + DMA_CHN_ID_W'(1);
    assign w_accept  = (r_state == ARB_GRANT) & grant_rdy_i;

    // Fresh selection out of IDLE starts at the round-robin pointer.
    adma_rr_pick #(.REQ_NUM(DMA_CHN_NUM)) u_pick_new (
        .i_elig  (w_elig),
        .i_start (r_rr_ptr),
        .o_found (w_new_found),
        .o_idx   (w_new_idx)
    );

    // Rotation after a quantum ends scans from cur+1, so cur itself comes last.
    adma_rr_pick #(.REQ_NUM(DMA_CHN_NUM)) u_pick_rot (
        .i_elig  (w_elig),
        .i_start (w_cur_inc),
        .o_found (w_rot_found),
        .o_idx   (w_rot_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_credit_nxt = r_credit;
        w_rr_ptr_nxt = r_rr_ptr;
        w_last_nxt   = r_last;

        unique case (r_state)
            ARB_IDLE: begin
                if (w_new_found) begin
                    w_state_nxt  = ARB_GRANT;
                    w_cur_nxt    = w_new_idx;
                    w_credit_nxt = w_q[w_new_idx];
                    w_last_nxt   = (w_q[w_new_idx] == DMA_CHN_ARB_W'(1)) | ~chn_req_i[w_new_idx];
                end
            end
            ARB_GRANT: begin
                if (w_accept) begin
                    if ((r_credit > DMA_CHN_ARB_W'(1)) && w_elig[r_cur]) begin
                        // Quantum not exhausted and the channel still has work.
                        w_credit_nxt = r_credit - DMA_CHN_ARB_W'(1);
                        w_last_nxt   = (r_credit == DMA_CHN_ARB_W'(2)) | ~chn_req_i[r_cur];
                    end else begin
                        w_rr_ptr_nxt = w_cur_inc;
                        if (w_rot_found) begin
                            w_cur_nxt    = w_rot_idx;
                            w_credit_nxt = w_q[w_rot_idx];
                            w_last_nxt   = (w_q[w_rot_idx] == DMA_CHN_ARB_W'(1)) | ~chn_req_i[w_rot_idx];
                        end else begin
                            w_state_nxt = ARB_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= ARB_IDLE;
            r_cur    <= '0;
            r_credit <= '0;
            r_rr_ptr <= '0;
            r_last   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_credit <= w_credit_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign grant_vld_o  = (r_state == ARB_GRANT);
    assign grant_chn_o  = r_cur;
    assign grant_last_o = r_last;
    assign arb_busy_o   = (r_state != ARB_IDLE);

    always_comb begin
        grant_oh_o = '0;
        if (grant_vld_o) begin
            grant_oh_o[r_cur] = 1'b1;
        end
    end

endmodule

// File: tb/tb_adma_chn_arbiter.sv
module tb_adma_chn_arbiter;
    import adma_pkg::*;

    localparam int N = 4;
    localparam int W = 3;

    logic         aclk;
    logic         areset;
    logic         dma_en;
    logic         chn_ctrl_en  [0:N-1];
    logic [W-1:0] chn_arb_rate [0:N-1];
    logic         chn_req_i    [0:N-1];
    logic         grant_vld_o;
    logic         grant_rdy_i;
    adma_chn_id_t grant_chn_o;
    logic [N-1:0] grant_oh_o;
    logic         grant_last_o;
    logic         arb_busy_o;

    int n_chk;
    int n_err;

    adma_chn_arbiter #(.DMA_CHN_NUM(N), .DMA_CHN_ARB_W(W)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .dma_en       (dma_en),
        .chn_ctrl_en  (chn_ctrl_en),
        .chn_arb_rate (chn_arb_rate),
        .chn_req_i    (chn_req_i),
        .grant_vld_o  (grant_vld_o),
        .grant_rdy_i  (grant_rdy_i),
        .grant_chn_o  (grant_chn_o),
        .grant_oh_o   (grant_oh_o),
        .grant_last_o (grant_last_o),
        .arb_busy_o   (arb_busy_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Outputs are registered, so sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] m);
        for (int i = 0; i < N; i++) chn_req_i[i] = m[i];
    endtask

    task automatic set_en(input logic [3:0] m);
        for (int i = 0; i < N; i++) chn_ctrl_en[i] = m[i];
    endtask

    task automatic set_rates(input int r0, input int r1, input int r2, input int r3);
        chn_arb_rate[0] = W'(r0);
        chn_arb_rate[1] = W'(r1);
        chn_arb_rate[2] = W'(r2);
        chn_arb_rate[3] = W'(r3);
    endtask

    task automatic exp_grant(input string tag, input int chn, input logic last);
        logic [3:0] oh;
        oh = 4'b0001 << chn;
        chk({tag, "_vld"},  32'(grant_vld_o),  32'd1);
        chk({tag, "_chn"},  32'(grant_chn_o),  32'(chn));
        chk({tag, "_last"}, 32'(grant_last_o), 32'(last));
        chk({tag, "_oh"},   32'(grant_oh_o),   32'(oh));
        chk({tag, "_busy"}, 32'(arb_busy_o),   32'd1);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_vld"},  32'(grant_vld_o), 32'd0);
        chk({tag, "_oh"},   32'(grant_oh_o),  32'd0);
        chk({tag, "_busy"}, 32'(arb_busy_o),  32'd0);
    endtask

    task automatic do_reset();
        areset      = 1'b1;
        grant_rdy_i = 1'b0;
        set_req(4'b0000);
        tick();
        areset = 1'b0;
    endtask

    initial begin
        int seq_chn [9];
        logic seq_last [9];
        n_chk = 0;
        n_err = 0;

        areset      = 1'b1;
        dma_en      = 1'b0;
        grant_rdy_i = 1'b0;
        set_en(4'b0000);
        set_req(4'b0000);
        set_rates(0, 0, 0, 0);
        tick();
        tick();
        exp_idle("rst");
        chk("rst_chn",  32'(grant_chn_o),  32'd0);
        chk("rst_last", 32'(grant_last_o), 32'd0);
        areset = 1'b0;

        // Weighted rotation: rates {2,1,0,3}
        seq_chn  = '{0, 0, 1, 2, 3, 3, 3, 0, 0};
        seq_last = '{0, 1, 1, 1, 0, 0, 1, 0, 1};
        set_rates(2, 1, 0, 3);
        set_en(4'b1111);
        set_req(4'b1111);
        dma_en      = 1'b1;
        grant_rdy_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_grant($sformatf("wrr%0d", i), seq_chn[i], seq_last[i]);
        end

        // Backpressure on the first grant to ch0
        do_reset();
        set_rates(2, 1, 1, 1);
        set_req(4'b0001);
        tick();
        exp_grant("bp_first", 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_grant($sformatf("bp_hold%0d", i), 0, 1'b0);
        end
        grant_rdy_i = 1'b1;
        tick();
        exp_grant("bp_acc", 0, 1'b1);
        grant_rdy_i = 1'b0;
        tick();
        exp_grant("bp_once", 0, 1'b1);
        grant_rdy_i = 1'b1;
        tick();
        exp_grant("bp_reload", 0, 1'b0);

        // Early request drop: ch0 gives up after its first accept
        do_reset();
        set_rates(3, 1, 1, 1);
        set_req(4'b0101);
        grant_rdy_i = 1'b1;
        tick();
        exp_grant("drop_ch0", 0, 1'b0);
        chn_req_i[0] = 1'b0;
        tick();
        exp_grant("drop_ch2", 2, 1'b1);
        chn_req_i[2] = 1'b0;
        tick();
        exp_idle("drop_idle");

        // Single requester keeps reloading its quantum
        do_reset();
        set_rates(1, 2, 1, 1);
        set_req(4'b0010);
        grant_rdy_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_grant($sformatf("single%0d", i), 1, 1'(i % 2));
        end

        // Gating by dma_en
        do_reset();
        set_rates(1, 1, 1, 1);
        set_req(4'b1111);
        dma_en      = 1'b0;
        grant_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_idle($sformatf("gate_off%0d", i));
        end
        dma_en      = 1'b1;
        grant_rdy_i = 1'b0;
        tick();
        exp_grant("gate_on", 0, 1'b1);
        dma_en = 1'b0;
        tick();
        exp_grant("gate_hold0", 0, 1'b1);
        tick();
        exp_grant("gate_hold1", 0, 1'b1);
        grant_rdy_i = 1'b1;
        tick();
        exp_idle("gate_done");

        // rr_ptr moved to 1 by the last rotation; reset mid-grant
        dma_en      = 1'b1;
        grant_rdy_i = 1'b0;
        tick();
        exp_grant("ptr1", 1, 1'b1);
        areset = 1'b1;
        tick();
        exp_idle("midrst");
        chk("midrst_chn",  32'(grant_chn_o),  32'd0);
        chk("midrst_last", 32'(grant_last_o), 32'd0);
        areset = 1'b0;
        set_req(4'b1000);
        tick();
        exp_grant("after_rst_ch3", 3, 1'b1);

        // Pointer restarts at 0 after reset: ch0 wins over ch3
        do_reset();
        set_req(4'b1001);
        tick();
        exp_grant("ptr0", 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
